div_seq_unit: RTL
=================

Name: div_seq_unit

Overview:
- Iterative radix-2 sequencer for the RV32M divide class: DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in EX. The pipeline hands off an operation, stalls on in_ready/out_valid, then collects a 32-bit result.
- Owns operand sign conditioning, a 32-step restoring shift/subtract loop, RISC-V special-case results and the flush abort.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; aborts any operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- op_i  in  div_op_e  DIV/DIVU/REM/REMU.
- a_i  in  XLEN  dividend (rs1).
- b_i  in  XLEN  divisor (rs2).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result_o  out  XLEN  quotient or remainder per op.
- busy_o  out  1  state != IDLE; feeds the hazard unit stall.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all datapath regs 0, out_valid 0, result_o 0, busy_o 0, in_ready 1 once released.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_valid & in_ready at edge 0 latches op, sign flags and operand magnitudes.
  - Divisor == 0 -> DONE: quotient all-ones (0xFFFFFFFF), remainder = a_i, both ops.
  - Signed op with a_i = 0x80000000 and b_i = 0xFFFFFFFF -> DONE: quotient 0x80000000, remainder 0.
  - Otherwise -> CALC, counter 0.
- CALC:
  - One iteration per cycle: shift {rem,quo} left 1, trial-subtract divisor magnitude, set quotient LSB on non-negative result.
  - After the 32nd iteration (counter 31) -> DONE.
- DONE:
  - out_valid = 1; result_o is stable and held until out_ready.
  - out_valid & out_ready -> IDLE. No back-to-back acceptance in the same cycle.
- Latency: a normal op presents out_valid from edge 33 (accept = edge 0). Special cases present out_valid from edge 1.
- Sign fix-up, applied at the CALC->DONE transition:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Unsigned ops bypass fix-up.
- Arithmetic: the trial subtract is XLEN+1 bits wide. Magnitude of 0x80000000 is 0x80000000 unsigned, with no overflow.
- flush_i:
  - Any state -> IDLE next edge; out_valid deasserts; no result is delivered.
  - flush_i takes priority over a simultaneous in_valid or out_ready.
- in_valid while busy is ignored (in_ready=0). Inputs are sampled only at acceptance.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, when divisor magnitude > dividend magnitude (unsigned compare, nonzero divisor, not the overflow case), go straight to DONE with quotient 0 and remainder = a_i. out_valid is presented from edge 1.
- Not defined: that case runs the full 32 iterations and gives the same values at edge 33.

Decomposition:
- rv32_pkg:
  - typedef enum div_op_e {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU}.
  - typedef enum div_state_e {DIV_IDLE, DIV_CALC, DIV_DONE}.
  - localparam DIV_ITERS = 32.
- One natural sub-module, div_step: combinational single-iteration shift/trial-subtract, instantiated once in CALC.
- Control, sign conditioning and the FSM remain in div_seq_unit.

Test Plan:
- DIVU a=100, b=7 -> out_valid from edge 33, result 14. Same operands with REMU -> 2.
- DIV a=-20 (0xFFFFFFEC), b=3 -> 0xFFFFFFFA (-6). REM on the same operands -> 0xFFFFFFFE (-2).
- DIV a=123, b=0 -> 0xFFFFFFFF at edge 1. REMU a=123, b=0 -> 123.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at edge 1. REM on the same operands -> 0.
- Start DIVU 1000/3; assert flush_i at edge 10 -> IDLE at edge 11, out_valid never high, in_ready=1. Then offer a new op -> correct result.
- Hold out_ready=0 for 5 cycles in DONE -> result_o stable, in_ready=0. DIVU 5/9 -> edge 1 with DIV_EARLY_OUT_EN defined, edge 33 without; result 0 in both builds.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and helpers for the RV32M divide sequencer
package rv32_pkg;

  typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift/trial-subtract iteration
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] quo_n
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // The partial remainder stays below the divisor, so the XLEN+1-bit
  // difference never wraps and its MSB is a clean borrow flag.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = ~diff[XLEN];

  assign rem_n = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - iterative radix-2 DIV/DIVU/REM/REMU sequencer (DIV_EARLY_OUT_EN: small-quotient bypass)
module div_seq_unit
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  div_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  div_op_e         op_q;
  logic            a_neg_q, b_neg_q;
  logic [XLEN-1:0] dvs_q, rem_q, quo_q, res_q;

  logic            accept, in_signed, in_rem;
  logic            a_neg, b_neg, b_zero, ovf, early;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] rem_n, quo_n, fix_quo, fix_rem;

  assign accept    = in_valid & in_ready & ~flush_i;
  assign in_signed = op_is_signed(op_i);
  assign in_rem    = op_is_rem(op_i);
  assign a_neg     = in_signed & a_i[XLEN-1];
  assign b_neg     = in_signed & b_i[XLEN-1];
  assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
  assign b_zero    = (b_i == '0);
  assign ovf       = in_signed & (a_i == INT_MIN) & (b_i == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
  assign early = ~b_zero & ~ovf & (b_mag > a_mag);
`else
  assign early = 1'b0;
`endif

  // Results that need no iteration; a zero divisor wins over everything else.
  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = in_rem ? a_i : ALL_ONES;
    else if (ovf)
      special_res = in_rem ? '0 : INT_MIN;
    else
      special_res = in_rem ? a_i : '0;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem   (rem_q),
    .quo   (quo_q),
    .dvs   (dvs_q),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  assign fix_quo = (op_is_signed(op_q) & (a_neg_q ^ b_neg_q)) ? (~quo_n + 1'b1) : quo_n;
  assign fix_rem = (op_is_signed(op_q) & a_neg_q) ? (~rem_n + 1'b1) : rem_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= DIV_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (accept) state_d = (b_zero | ovf | early) ? DIV_DONE : DIV_CALC;
        DIV_CALC: if (cnt_q == LAST_CNT) state_d = DIV_DONE;
        DIV_DONE: if (out_ready) state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= DIV_DIV;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
    end else if (!flush_i) begin
      if (accept) begin
        op_q    <= op_i;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        dvs_q   <= b_mag;
        rem_q   <= '0;
        quo_q   <= a_mag;
        cnt_q   <= '0;
        if (b_zero | ovf | early)
          res_q <= special_res;
      end else if (state_q == DIV_CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST_CNT)
          res_q <= op_is_rem(op_q) ? fix_rem : fix_quo;
      end
    end
  end

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = (state_q == DIV_DONE);
  assign busy_o    = (state_q != DIV_IDLE);
  assign result_o  = res_q;

endmodule
